// File: rtl/destuffer.sv
// Bit de-stuffer: oversamples a bit-stuffed serial line at mid-bit, removes the
// bit inserted after every run of five identical bits and flags stuffing errors.
module destuffer (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rxin_i,
    input  logic       rxi_i,
    input  logic [7:0] baudrate_i,
    output logic       dout_o,
    output logic       dvalid_o,
    output logic       stuffbit_o,
    output logic       stufferr_o,
    output logic       frame_done_o,
    output logic [7:0] bitcount_o
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e     state_q, state_d;
    logic [7:0] baud_q, baud_d;         // position inside the bit period, 1..B
    logic [7:0] bper_q, bper_d;         // bit period in use, reloaded at each wrap
    logic [7:0] bitcount_q, bitcount_d;
    logic [2:0] runlen_q, runlen_d;
    logic       runval_q, runval_d;
    logic       stufferr_q, stufferr_d;
    logic       dout_q, dout_d;
    logic       dvalid_q, dvalid_d;
    logic       stuffbit_q, stuffbit_d;

    logic [7:0] baud_eff;
    logic [7:0] half;
    logic       sample;
    logic       frame_end;

    // Baudrate 0 and 1 both mean one cycle per bit.
    assign baud_eff = (baudrate_i == 8'd0) ? 8'd1 : baudrate_i;
    // ceil(B/2) without a carry bit.
    assign half     = {1'b0, bper_q[7:1]} + {7'd0, bper_q[0]};
    assign sample   = (state_q == StRun) && !rxi_i && (baud_q == half);
    assign frame_end = (state_q == StRun) && rxi_i;

    // Next-state logic: frame start/end, bit-period counter and run tracking.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bper_d     = bper_q;
        bitcount_d = bitcount_q;
        runlen_d   = runlen_q;
        runval_d   = runval_q;
        stufferr_d = stufferr_q;
        dout_d     = dout_q;
        dvalid_d   = 1'b0;
        stuffbit_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (!rxi_i) begin
                    state_d    = StRun;
                    baud_d     = 8'd1;
                    bper_d     = baud_eff;
                    runlen_d   = 3'd0;
                    bitcount_d = 8'd0;
                    stufferr_d = 1'b0;
                end
            end
            StRun: begin
                if (rxi_i) begin
                    // Partially elapsed bit period is simply abandoned.
                    state_d = StIdle;
                end else begin
                    if (baud_q >= bper_q) begin
                        baud_d = 8'd1;
                        bper_d = baud_eff;
                    end else begin
                        baud_d = baud_q + 8'd1;
                    end

                    if (sample) begin
                        dout_d = rxin_i;
                        if (runlen_q == 3'd5) begin
                            stuffbit_d = 1'b1;
                            if (rxin_i == runval_q) begin
                                stufferr_d = 1'b1;
                            end
                            runval_d = rxin_i;
                            runlen_d = 3'd1;
                        end else begin
                            dvalid_d = 1'b1;
                            // runlen 0 (frame start) also lands on 1 either way.
                            if (rxin_i == runval_q) begin
                                runlen_d = runlen_q + 3'd1;
                            end else begin
                                runval_d = rxin_i;
                                runlen_d = 3'd1;
                            end
                            if (bitcount_q != 8'hFF) begin
                                bitcount_d = bitcount_q + 8'd1;
                            end
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            baud_q     <= 8'd1;
            bper_q     <= 8'd1;
            bitcount_q <= 8'd0;
            runlen_q   <= 3'd0;
            runval_q   <= 1'b0;
            stufferr_q <= 1'b0;
            dout_q     <= 1'b0;
            dvalid_q   <= 1'b0;
            stuffbit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bper_q     <= bper_d;
            bitcount_q <= bitcount_d;
            runlen_q   <= runlen_d;
            runval_q   <= runval_d;
            stufferr_q <= stufferr_d;
            dout_q     <= dout_d;
            dvalid_q   <= dvalid_d;
            stuffbit_q <= stuffbit_d;
        end
    end

    // Strobes are masked in the frame-end and reset cycles so at most one is high.
    always_comb begin
        frame_done_o = frame_end && !reset_i;
        dvalid_o     = dvalid_q && !frame_end && !reset_i;
        stuffbit_o   = stuffbit_q && !frame_end && !reset_i;
        dout_o       = dout_q;
        stufferr_o   = stufferr_q;
        bitcount_o   = bitcount_q;
    end

endmodule
